// File: rtl/run_hit_counter_if.sv
// run_hit_counter_if: frame control, the qualified hit stream, and the
// valid/ready result handshake for run_hit_counter.
// The slave modport is the counter; the master modport is the stimulus/consumer side.
interface run_hit_counter_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             en;
  logic             hit_in;
  logic [CNT_W-1:0] count_out;
  logic             count_valid;
  logic             count_ready;
  logic             busy;
  logic             ovf;

  modport slave (
    input  start, en, hit_in, count_ready,
    output count_out, count_valid, busy, ovf
  );

  modport master (
    output start, en, hit_in, count_ready,
    input  count_out, count_valid, busy, ovf
  );
endinterface

// File: rtl/run_hit_counter.sv
// run_hit_counter: counts run-detector hits over a frame of FRAME_LEN
// qualified bits and holds the total on a valid/ready handshake until it is
// accepted.
// Optional feature macro: RHC_SATURATE_EN. When it is defined, totals
// saturate at 2^CNT_W-1 and ovf flags a saturated frame. When it is not
// defined, totals wrap and ovf is held at 0.
module run_hit_counter #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  run_hit_counter_if.slave   bus
);
  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BW-1:0] LAST = BW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

  state_t           r_state;
  logic [BW-1:0]    r_bit_cnt;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_count_out;
  logic             r_count_valid;
  logic             r_busy;
  logic [CNT_W-1:0] w_next;

`ifdef RHC_SATURATE_EN
  logic             r_sat;
  logic             r_ovf;
  logic [CNT_W:0]   w_sum;
  logic             w_carry;

  // Running total plus the current bit; the carry out means the total has
  // passed the top of the range, so the total is clamped to all ones.
  always_comb begin
    w_sum   = {1'b0, r_hit_cnt} + {{CNT_W{1'b0}}, bus.hit_in};
    w_carry = w_sum[CNT_W];
    w_next  = w_carry ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
  end
`else
  // Running total plus the current bit, wrapping modulo 2^CNT_W.
  always_comb begin
    w_next = r_hit_cnt + CNT_W'(bus.hit_in);
  end
`endif

  // Frame control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_bit_cnt     <= '0;
      r_hit_cnt     <= '0;
      r_count_out   <= '0;
      r_count_valid <= 1'b0;
      r_busy        <= 1'b0;
`ifdef RHC_SATURATE_EN
      r_sat         <= 1'b0;
      r_ovf         <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // en/hit_in in the start cycle are not counted.
          if (bus.start) begin
            r_state   <= S_COUNT;
            r_busy    <= 1'b1;
            r_bit_cnt <= '0;
            r_hit_cnt <= '0;
`ifdef RHC_SATURATE_EN
            r_sat     <= 1'b0;
`endif
          end
        end
        S_COUNT: begin
          if (bus.en) begin
            if (r_bit_cnt == LAST) begin
              r_count_out   <= w_next;
              r_count_valid <= 1'b1;
              r_busy        <= 1'b0;
              r_state       <= S_DONE;
`ifdef RHC_SATURATE_EN
              r_ovf         <= r_sat | w_carry;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
              r_hit_cnt <= w_next;
`ifdef RHC_SATURATE_EN
              r_sat     <= r_sat | w_carry;
`endif
            end
          end
        end
        S_DONE: begin
          // The result is held until the consumer accepts it; start is
          // ignored even in the accept cycle.
          if (bus.count_ready) begin
            r_count_valid <= 1'b0;
            r_state       <= S_IDLE;
`ifdef RHC_SATURATE_EN
            r_ovf         <= 1'b0;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.count_out   = r_count_out;
  assign bus.count_valid = r_count_valid;
  assign bus.busy        = r_busy;
`ifdef RHC_SATURATE_EN
  assign bus.ovf         = r_ovf;
`else
  assign bus.ovf         = 1'b0;
`endif

endmodule

// File: tb/tb_run_hit_counter.sv
// tb_run_hit_counter: drives one stimulus stream into two counters,
// FRAME_LEN=8 with CNT_W=4 and FRAME_LEN=8 with CNT_W=2. Expected totals
// are computed from the hit pattern of each frame.
module tb_run_hit_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, en = 1'b0, hit = 1'b0, ready = 1'b0;

  int checks = 0;
  int errors = 0;

  run_hit_counter_if #(.CNT_W(4)) u_if4 ();
  run_hit_counter_if #(.CNT_W(2)) u_if2 ();

  assign u_if4.start = start;  assign u_if2.start = start;
  assign u_if4.en    = en;     assign u_if2.en    = en;
  assign u_if4.hit_in = hit;   assign u_if2.hit_in = hit;
  assign u_if4.count_ready = ready;
  assign u_if2.count_ready = ready;

  run_hit_counter #(.FRAME_LEN(8), .CNT_W(4)) u_dut (.clk(clk), .rst(rst), .bus(u_if4));
  run_hit_counter #(.FRAME_LEN(8), .CNT_W(2)) u_sat (.clk(clk), .rst(rst), .bus(u_if2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected 2-bit total for a frame containing n hits.
  function automatic int exp2(input int n);
`ifdef RHC_SATURATE_EN
    return (n > 3) ? 3 : n;
`else
    return n % 4;
`endif
  endfunction

  function automatic int expovf2(input int n);
`ifdef RHC_SATURATE_EN
    return (n > 3) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_cnt4"},  u_if4.count_out, 0);
    chk({tag, "_vld4"},  u_if4.count_valid, 0);
    chk({tag, "_busy4"}, u_if4.busy, 0);
    chk({tag, "_ovf4"},  u_if4.ovf, 0);
    chk({tag, "_cnt2"},  u_if2.count_out, 0);
    chk({tag, "_vld2"},  u_if2.count_valid, 0);
    chk({tag, "_ovf2"},  u_if2.ovf, 0);
  endtask

  // One complete frame: start, 8 qualified bits (optionally with gaps),
  // bp cycles of backpressure, then acceptance.
  task automatic run_frame(input logic [7:0] pat, input bit gaps, input bit st_hit, input int bp);
    int n;
    n = $countones(pat);
    start = 1'b1; en = st_hit; hit = st_hit; ready = 1'($urandom % 2);
    step();
    chk("busy_rise", u_if4.busy, 1);
    chk("vld_lo_start", u_if4.count_valid, 0);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        repeat ($urandom_range(1, 2)) begin
          en = 1'b0; hit = 1'b1; start = 1'($urandom % 2); ready = 1'($urandom % 2);
          step();
          chk("gap_busy", u_if4.busy, 1);
          chk("gap_vld", u_if4.count_valid, 0);
        end
      end
      en = 1'b1; hit = pat[i]; start = 1'($urandom % 2); ready = 1'($urandom % 2);
      step();
      if (i < 7) begin
        chk("bit_busy", u_if4.busy, 1);
        chk("bit_vld", u_if4.count_valid, 0);
      end
    end
    en = 1'b0; hit = 1'b0; start = 1'b0; ready = 1'b0;
    chk("done_vld4", u_if4.count_valid, 1);
    chk("done_busy4", u_if4.busy, 0);
    chk("done_cnt4", u_if4.count_out, 32'(n));
    chk("done_ovf4", u_if4.ovf, 0);
    chk("done_vld2", u_if2.count_valid, 1);
    chk("done_cnt2", u_if2.count_out, 32'(exp2(n)));
    chk("done_ovf2", u_if2.ovf, 32'(expovf2(n)));
    repeat (bp) begin
      start = 1'($urandom % 2); en = 1'($urandom % 2); hit = 1'($urandom % 2);
      step();
      chk("bp_vld", u_if4.count_valid, 1);
      chk("bp_busy", u_if4.busy, 0);
      chk("bp_cnt4", u_if4.count_out, 32'(n));
      chk("bp_cnt2", u_if2.count_out, 32'(exp2(n)));
    end
    // The start asserted in the accept cycle must be ignored.
    ready = 1'b1; start = 1'b1; en = 1'b1; hit = 1'b1;
    step();
    ready = 1'b0; start = 1'b0; en = 1'b0; hit = 1'b0;
    chk("acc_vld4", u_if4.count_valid, 0);
    chk("acc_vld2", u_if2.count_valid, 0);
    chk("acc_busy", u_if4.busy, 0);
    chk("acc_ovf2", u_if2.ovf, 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk_zero("reset");
    step();
    step();
    rst = 1'b0;
    step();
    chk_zero("post_reset");
    // A count_ready pulse while count_valid is low must have no effect.
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk_zero("idle_ready");

    run_frame(8'b1000_1101, 1'b0, 1'b0, 0);   // basic frame, 4 hits
    run_frame(8'b1000_1101, 1'b1, 1'b0, 0);   // gaps carrying hit_in=1
    run_frame(8'b0000_0000, 1'b0, 1'b1, 0);   // start-cycle hit excluded
    run_frame(8'b0110_0101, 1'b0, 1'b0, 5);   // backpressure
    run_frame(8'b1111_1111, 1'b0, 1'b0, 1);   // 2-bit saturation / wrap

    // Asynchronous reset mid-frame, after 3 hits.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) begin
      en = 1'b1; hit = 1'b1;
      step();
    end
    en = 1'b0; hit = 1'b0;
    rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    chk("mid_rst_busy2", u_if2.busy, 0);
    step();
    rst = 1'b0;
    run_frame(8'b0100_1000, 1'b0, 1'b0, 0);   // 2 hits after reset

    for (int f = 0; f < 20; f++) begin
      logic [7:0] p;
      p = 8'($urandom);
      run_frame(p, 1'($urandom % 2), 1'($urandom % 2), int'($urandom_range(0, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
